// File: rtl/dco_prog_div_if.sv
// Code-load handshake bundle for dco_prog_div: mode/code offered with valid, accepted on ready.
interface dco_prog_div_if #(
  parameter int unsigned CODE_W = 8
) ();
  logic              mode;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;

  modport master (output mode, code, code_valid, input code_ready);
  modport slave  (input mode, code, code_valid, output code_ready);
endinterface

// File: rtl/dco_prog_div.sv
// Programmable-divider DCO with a one-entry pending code slot applied only at toggle boundaries.
// Optional synchronous phase clear is enabled by defining DCO_PHASE_CLR_EN.
module dco_prog_div #(
  parameter int unsigned CODE_W       = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 50,
  parameter int unsigned BASE         = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
`ifdef DCO_PHASE_CLR_EN
  input  logic           phase_clr,
`endif
  dco_prog_div_if.slave  code_if,
  output logic           dco_out,
  output logic           edge_pulse
);

  localparam int unsigned MaxHalf = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);
  localparam logic [CNT_W-1:0] DefHalf =
      CNT_W'((DEFAULT_HALF > MaxHalf) ? MaxHalf : DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             pend_vld_q, pend_vld_d;
  logic             dco_q, dco_d;
  logic             edge_q, edge_d;

  int unsigned      msb_idx;
  int unsigned      raw_half;
  logic [CNT_W-1:0] dec_half;
  logic             accept;
  logic             toggle;

  // Decode at acceptance so the slot always holds a ready-to-use half-period.
  always_comb begin
    msb_idx = 0;
    for (int i = 0; i < int'(CODE_W); i++) begin
      if (code_if.code[i]) msb_idx = 32'(i);
    end
    if (code_if.mode) begin
      raw_half = (code_if.code == '0) ? 32'd1 : 32'(code_if.code);
    end else begin
      raw_half = (code_if.code == '0) ? DEFAULT_HALF : (BASE + msb_idx);
    end
    dec_half = (raw_half > MaxHalf) ? CNT_W'(MaxHalf) : CNT_W'(raw_half);
  end

  assign code_if.code_ready = ~pend_vld_q;
  assign accept             = code_if.code_valid & ~pend_vld_q;
  assign toggle             = en & (cnt_q == half_q);

  always_comb begin
    cnt_d       = cnt_q;
    half_d      = half_q;
    pend_half_d = pend_half_q;
    pend_vld_d  = pend_vld_q;
    dco_d       = dco_q;
    edge_d      = 1'b0;

    if (toggle) begin
      cnt_d  = '0;
      dco_d  = ~dco_q;
      edge_d = 1'b1;
      if (pend_vld_q) begin
        half_d     = pend_half_q;
        pend_vld_d = 1'b0;
      end
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

`ifdef DCO_PHASE_CLR_EN
    if (phase_clr) begin
      cnt_d  = '0;
      dco_d  = 1'b0;
      edge_d = 1'b0;
      if (pend_vld_q) begin
        half_d     = pend_half_q;
        pend_vld_d = 1'b0;
      end
    end
`endif

    // Accept only when the slot was empty, so it never collides with a drain.
    if (accept) begin
      pend_half_d = dec_half;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      half_q      <= DefHalf;
      pend_half_q <= '0;
      pend_vld_q  <= 1'b0;
      dco_q       <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      pend_vld_q  <= pend_vld_d;
      dco_q       <= dco_d;
      edge_q      <= edge_d;
    end
  end

  assign dco_out    = dco_q;
  assign edge_pulse = edge_q;

endmodule

// File: doc/dco_prog_div.md
# dco_prog_div

Parametrised digitally controlled oscillator for on-die clock-generation experiments. It succeeds the fixed 8-bit DCO with:
- configurable code and counter widths;
- a selectable code interpretation (priority-encoded or direct binary);
- a valid/ready handshake for loading new codes;
- glitch-free period updates that take effect only at output toggle boundaries.

It sits between the top-level input pins, or a host register, and the oscillator output pin.

## Interface
- CODE_W, 8: width of the frequency code.
- CNT_W, 8: width of the half-period counter and the half-period register.
- DEFAULT_HALF, 50: half-period loaded at reset, and used for an all-zero code in priority mode.
- BASE, 3: half-period for priority index 0 (code LSB only).
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  count enable; low freezes the oscillator.
- mode  input  1  0 = priority code, 1 = binary code; sampled together with code.
- code  input  CODE_W  frequency code.
- code_valid  input  1  code/mode offered.
- code_ready  output  1  block can accept a code.
- dco_out  output  1  oscillator output.
- edge_pulse  output  1  one-cycle pulse in the cycle after each dco_out toggle.

## Operation
- State:
  - cnt (CNT_W);
  - half_q (CNT_W): active half-period;
  - pend_half (CNT_W) and pend_vld: a one-entry pending slot.
- Code decode happens at acceptance; pend_half holds the decoded value.
  - Priority mode, code != 0: half = BASE + index of the highest set bit (LSB = index 0). With defaults, 0x80 gives 10 and 0x01 gives 3.
  - Priority mode, code == 0: half = DEFAULT_HALF.
  - Binary mode: half = code, with two adjustments:
    - if CODE_W > CNT_W and the code exceeds 2^CNT_W-1, it saturates to 2^CNT_W-1;
    - 0 clamps to 1.
  - Priority-mode results wider than CNT_W also saturate.
- Handshake:
  - code_ready = ~pend_vld (a registered-state function, with no combinational path from code_valid).
  - Transfer happens when code_valid & code_ready at a clk edge: pend_half is loaded and pend_vld is set.
- Oscillation (only while en=1):
  - cnt != half_q: cnt increments.
  - cnt == half_q: this is a toggle cycle. dco_out inverts and cnt clears to 0.
    - If pend_vld, half_q <= pend_half and pend_vld clears.
  - Each output half-period is therefore half_q+1 enabled clk cycles, and the full period is 2*(half_q+1).
- en=0:
  - cnt, dco_out and half_q hold;
  - edge_pulse is 0;
  - the handshake still operates, and a pending code waits for the next toggle.
- Boundary conditions:
  - Transfer in a toggle cycle with the slot empty: the code goes into the slot and is applied at the following toggle, not the current one.
  - Slot full: code_ready=0 until the toggle cycle that drains it. The slot is writable again from the next cycle.
  - half_q never changes except in a toggle cycle, so there are no runt pulses.
  - cnt never exceeds half_q, so it never wraps.
- Reset (rst_n=0 at a clk edge):
  - cnt=0, dco_out=0, edge_pulse=0;
  - half_q=DEFAULT_HALF (saturated to CNT_W);
  - pend_vld=0, so code_ready=1.
  - Any pending code is discarded.
  - Reset overrides every other input in the same cycle.

## Timing
- All outputs are registered, except code_ready, which is a direct decode of pend_vld.
- Transfer at edge N: pend_vld=1 and code_ready=0 from after edge N.
- Toggle cycle at edge T:
  - dco_out flips after T;
  - edge_pulse is high for exactly the cycle after T;
  - the new half_q governs counting from T onward.
- After reset release with en=1 held, the first dco_out rise occurs DEFAULT_HALF+1 edges later.
- Code-change latency:
  - from transfer to effect: at most one full current half-period plus one cycle;
  - minimum: 1 cycle, when the transfer lands one cycle before a toggle.

## Configuration
- DCO_PHASE_CLR_EN defined:
  - adds input phase_clr (1 bit);
  - phase_clr=1 at a clk edge, while rst_n=1, forces cnt=0, dco_out=0 and edge_pulse=0;
  - if pend_vld, it also applies pend_half to half_q immediately and clears pend_vld;
  - it works regardless of en;
  - simultaneous code transfer: the slot is cleared first, then the new code is loaded.
- Undefined: the phase_clr port is absent and no related logic is generated.

## Test plan
- Reset, then en=1, with no code offered -> dco_out rises 51 cycles after reset release, then toggles every 51 cycles. edge_pulse is seen once per toggle.
- Mode 0, code 0x80 accepted mid-half-period -> the current half completes at 51, then half-periods of 11 cycles. Code 0x01 -> half-periods of 4.
- Mode 1, code 0 -> clamped, half-periods of 2. Code 5 -> half-periods of 6. With CODE_W=10, CNT_W=8 and code 0x3FF -> half-periods of 256.
- Two back-to-back codes (0x40, then 0x02, mode 0):
  - code_ready drops after the first and rises only in the cycle after the next toggle;
  - the second code is accepted then;
  - the resulting half-periods are 51, 10, 5.
- en low for 7 cycles mid-count -> dco_out holds, and that half-period stretches by exactly 7 cycles. A code accepted while en is low is applied at the next toggle.
- rst_n low for one cycle with a code pending -> all outputs take their reset values and the pending code is lost. With DCO_PHASE_CLR_EN, a phase_clr pulse instead yields dco_out=0 next cycle and the pending half-period is applied immediately.
